vlc_decompressor: RTL and testbench
===================================

# vlc_decompressor

- Receive side of the character compression path.
- Takes the serial variable-length code stream that the compressor emits, MSB first, and rebuilds the original 8-bit characters.
- Presents each character on a valid/ready byte interface and flags end-of-message markers.
- Sits between the channel bit receiver and the character sink.

## Interface

Parameters:
- CNT_W, 16, width of the decoded-symbol counter.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST_N  input  1  reset; one clock, reset is asynchronous and active-low.
- BIT_IN  input  1  compressed stream bit.
- BIT_VALID  input  1  BIT_IN is valid this cycle.
- BIT_READY  output  1  decoder accepts a bit this cycle.
- OUT  output  8  decoded character.
- OUT_VALID  output  1  OUT holds an undelivered character.
- OUT_READY  input  1  sink accepts OUT this cycle.
- EOM  output  1  one-cycle pulse when the end-of-message code is decoded.
- SYM_COUNT  output  CNT_W  characters decoded since reset or the last EOM.

## Operation

Code format (prefix code, bits MSB first):
- Flag bit 0, then 5-bit index, is a short code.
  - Index 0–25 -> 0x61+index ('a'–'z').
  - 26 -> 0x20 (space).
  - 27 -> 0x2E ('.').
  - 28 -> 0x2C (',').
  - 29 -> 0x21 ('!').
  - 30 -> 0x3F ('?').
  - 31 -> end-of-message (no character).
- Flag bit 1, then 8 literal bits, is a literal; OUT = those 8 bits.

FSM (state changes only on an accepted bit):
- FLAG:
  - Accepted 0 -> SHORT, bit counter = 5.
  - Accepted 1 -> LIT, bit counter = 8.
- SHORT: shift accepted bits into the index register. On the 5th bit:
  - Index ≠ 31: load OUT from the table, set OUT_VALID, increment SYM_COUNT. Next state FLAG.
  - Index = 31: EOM = 1 for the following cycle, SYM_COUNT <= 0, OUT_VALID unaffected. Next state FLAG.
- LIT: shift accepted bits. On the 8th bit, load OUT, set OUT_VALID, increment SYM_COUNT. Next state FLAG.

Flow control:
- Bit accepted at a rising edge iff BIT_VALID && BIT_READY.
- BIT_READY = !OUT_VALID || OUT_READY (combinational from OUT_READY).
- A character is delivered at an edge with OUT_VALID && OUT_READY; OUT_VALID clears unless a new character loads on the same edge.
- Simultaneous deliver and complete: OUT takes the new character and OUT_VALID stays 1.
- OUT is held stable while OUT_VALID = 1 and OUT_READY = 0.

Arithmetic and boundaries:
- SYM_COUNT wraps modulo 2^CNT_W.
- EOM reset of SYM_COUNT has priority over increment; they cannot coincide.

Reset (asynchronous, any state, mid-symbol included):
- State returns to FLAG; partial bits are discarded.
- OUT = 0x00, OUT_VALID = 0, EOM = 0, SYM_COUNT = 0.
- BIT_READY = 1 as soon as RST_N is high.

## Timing

- Latency: the last code bit accepted at edge k gives OUT and OUT_VALID valid after edge k. EOM is high for exactly the cycle after edge k.
- Throughput: one bit per cycle with the sink always ready. That is 6 cycles per short code and 9 cycles per literal.
- No bit is lost or duplicated under backpressure. BIT_VALID may drop between bits of a code with no effect.
- All outputs are registered except BIT_READY.

## Test plan

1. Reset check: hold RST_N = 0 -> OUT = 0x00, OUT_VALID = 0, EOM = 0, SYM_COUNT = 0; BIT_READY = 1 after release.
2. Short codes with OUT_READY = 1:
   - Stream 0_00001 -> OUT = 0x62 one cycle after the 6th bit.
   - Then 0_11010 -> 0x20.
   - SYM_COUNT = 2.
3. Literals:
   - Stream 1_01000010 -> 0x42.
   - Then 1_10100101 -> 0xA5.
   - Then 1_10000000 -> 0x80.
   - Each is valid after its 9th bit.
4. Backpressure: decode 0x62 with OUT_READY = 0 and BIT_VALID held high.
   - BIT_READY = 0 and OUT stays 0x62 for 10 cycles.
   - Raise OUT_READY: 0x62 is delivered and the next bit is accepted on the same edge.
   - The following code 0_00010 yields 0x63 with nothing lost.
5. End of message: 3 characters, then 0_11111 -> EOM high for exactly one cycle, SYM_COUNT 3 -> 0, no extra OUT_VALID.
6. Reset mid-operation: pulse RST_N low after 4 bits of a literal, then send 0_00000 -> OUT = 0x61, SYM_COUNT = 1.

Source files
------------

// File: rtl/vlc_decompressor.sv
// Serial variable-length code decoder: rebuilds 8-bit characters from an MSB-first
// prefix-coded bit stream and flags end-of-message markers.
module vlc_decompressor #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             BIT_IN,
  input  logic             BIT_VALID,
  output logic             BIT_READY,
  output logic [7:0]       OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             EOM,
  output logic [CNT_W-1:0] SYM_COUNT,
  output logic [1:0]       STATE_DBG
);

  localparam logic [1:0] S_FLAG  = 2'd0;
  localparam logic [1:0] S_SHORT = 2'd1;
  localparam logic [1:0] S_LIT   = 2'd2;

  // Handshakes: a bit moves on an edge with BIT_VALID && BIT_READY; a character
  // moves on an edge with OUT_VALID && OUT_READY. A new character can only
  // complete when the output slot is free or being drained on the same edge.

  logic [1:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] shifted;
  logic       accept;
  logic       last_bit;

  function automatic logic [7:0] short_char(input logic [4:0] idx);
    logic [7:0] c;
    c = 8'h00;
    case (idx)
      5'd26:   c = 8'h20;
      5'd27:   c = 8'h2E;
      5'd28:   c = 8'h2C;
      5'd29:   c = 8'h21;
      5'd30:   c = 8'h3F;
      default: c = 8'h61 + {3'b000, idx};
    endcase
    return c;
  endfunction

  assign BIT_READY = !OUT_VALID || OUT_READY;
  assign accept    = BIT_VALID && BIT_READY;
  assign shifted   = {shreg[6:0], BIT_IN};
  assign last_bit  = (bit_cnt == 4'd1);
  assign STATE_DBG = state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_FLAG;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      OUT       <= 8'h00;
      OUT_VALID <= 1'b0;
      EOM       <= 1'b0;
      SYM_COUNT <= '0;
    end else begin
      EOM <= 1'b0;
      if (OUT_VALID && OUT_READY) OUT_VALID <= 1'b0;
      if (accept) begin
        case (state)
          S_FLAG: begin
            shreg   <= 8'h00;
            bit_cnt <= BIT_IN ? 4'd8 : 4'd5;
            state   <= BIT_IN ? S_LIT : S_SHORT;
          end
          S_SHORT: begin
            shreg   <= shifted;
            bit_cnt <= bit_cnt - 4'd1;
            if (last_bit) begin
              state <= S_FLAG;
              if (shifted[4:0] == 5'd31) begin
                EOM       <= 1'b1;
                SYM_COUNT <= '0;
              end else begin
                OUT       <= short_char(shifted[4:0]);
                OUT_VALID <= 1'b1;
                SYM_COUNT <= SYM_COUNT + 1'b1;
              end
            end
          end
          S_LIT: begin
            shreg   <= shifted;
            bit_cnt <= bit_cnt - 4'd1;
            if (last_bit) begin
              state     <= S_FLAG;
              OUT       <= shifted;
              OUT_VALID <= 1'b1;
              SYM_COUNT <= SYM_COUNT + 1'b1;
            end
          end
          default: state <= S_FLAG;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vlc_decompressor.sv
// Directed bench for vlc_decompressor: short codes, literals, backpressure,
// end-of-message, counter wrap and mid-symbol reset.
module tb_vlc_decompressor;
  localparam int CNT_W = 4;

  logic             CLK;
  logic             RST_N;
  logic             BIT_IN;
  logic             BIT_VALID;
  logic             BIT_READY;
  logic [7:0]       OUT;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             EOM;
  logic [CNT_W-1:0] SYM_COUNT;
  logic [1:0]       STATE_DBG;

  int n_cmp  = 0;
  int n_fail = 0;

  vlc_decompressor #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .BIT_IN(BIT_IN), .BIT_VALID(BIT_VALID),
    .BIT_READY(BIT_READY), .OUT(OUT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .EOM(EOM), .SYM_COUNT(SYM_COUNT), .STATE_DBG(STATE_DBG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive at the negedge, wait (bounded) for BIT_READY, let the posedge take it.
  task automatic send_bit(input logic b, input int gap);
    int guard;
    guard = 0;
    BIT_IN = b;
    BIT_VALID = 1'b1;
    #1;
    while (!BIT_READY && guard < 50) begin
      @(negedge CLK);
      #1;
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL bit_ready_timeout got=%0b exp=1", BIT_READY);
    end
    @(posedge CLK);
    @(negedge CLK);
    BIT_VALID = 1'b0;
    for (int g = 0; g < gap; g++) @(negedge CLK);
  endtask

  task automatic send_code(input logic [8:0] code, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) send_bit(code[i], gap);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    BIT_IN = 1'b0;
    BIT_VALID = 1'b0;
    OUT_READY = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (OUT !== 8'h00 || OUT_VALID !== 1'b0 || EOM !== 1'b0 || SYM_COUNT !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got out=%h v=%b eom=%b cnt=%0d exp 00/0/0/0", OUT, OUT_VALID, EOM, SYM_COUNT);
    end
    RST_N = 1'b1;
    OUT_READY = 1'b0;
    #1;
    n_cmp++;
    if (BIT_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_bit_ready got=%b exp=1", BIT_READY);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_short();
    send_code(9'b0_00001, 6, 0);
    n_cmp++;
    if (OUT !== 8'h62 || OUT_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL short_b got out=%h v=%b exp 62/1", OUT, OUT_VALID);
    end
    send_code(9'b0_11010, 6, 0);
    n_cmp++;
    if (OUT !== 8'h20 || OUT_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL short_space got out=%h v=%b exp 20/1", OUT, OUT_VALID);
    end
    n_cmp++;
    if (SYM_COUNT !== 4'd2) begin
      n_fail++;
      $display("FAIL short_count got=%0d exp=2", SYM_COUNT);
    end
    send_code(9'b0_11001, 6, 0);
    n_cmp++;
    if (OUT !== 8'h7A) begin
      n_fail++;
      $display("FAIL short_z got=%h exp=7a", OUT);
    end
    send_code(9'b0_11011, 6, 0);
    n_cmp++;
    if (OUT !== 8'h2E) begin
      n_fail++;
      $display("FAIL short_dot got=%h exp=2e", OUT);
    end
    send_code(9'b0_11100, 6, 0);
    n_cmp++;
    if (OUT !== 8'h2C) begin
      n_fail++;
      $display("FAIL short_comma got=%h exp=2c", OUT);
    end
    send_code(9'b0_11101, 6, 0);
    n_cmp++;
    if (OUT !== 8'h21) begin
      n_fail++;
      $display("FAIL short_bang got=%h exp=21", OUT);
    end
    send_code(9'b0_11110, 6, 0);
    n_cmp++;
    if (OUT !== 8'h3F || SYM_COUNT !== 4'd7) begin
      n_fail++;
      $display("FAIL short_qmark got out=%h cnt=%0d exp 3f/7", OUT, SYM_COUNT);
    end
    @(negedge CLK);
    n_cmp++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL short_delivered got v=%b exp=0", OUT_VALID);
    end
  endtask

  task automatic test_literal();
    do_reset();
    send_code({1'b1, 8'h42}, 9, 0);
    n_cmp++;
    if (OUT !== 8'h42 || OUT_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL lit_42 got out=%h v=%b exp 42/1", OUT, OUT_VALID);
    end
    send_code({1'b1, 8'hA5}, 9, 0);
    n_cmp++;
    if (OUT !== 8'hA5 || OUT_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL lit_a5 got out=%h v=%b exp a5/1", OUT, OUT_VALID);
    end
    // Gaps between bits must not disturb the code.
    send_code({1'b1, 8'h80}, 9, 2);
    n_cmp++;
    if (OUT !== 8'h80 || SYM_COUNT !== 4'd3) begin
      n_fail++;
      $display("FAIL lit_80_gap got out=%h cnt=%0d exp 80/3", OUT, SYM_COUNT);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    OUT_READY = 1'b0;
    send_code(9'b0_00001, 6, 0);
    BIT_IN = 1'b0;
    BIT_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if (BIT_READY !== 1'b0 || OUT !== 8'h62 || OUT_VALID !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_stall cyc=%0d got rdy=%b out=%h v=%b exp 0/62/1", i, BIT_READY, OUT, OUT_VALID);
      end
      @(negedge CLK);
    end
    OUT_READY = 1'b1;
    #1;
    n_cmp++;
    if (BIT_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready got=%b exp=1", BIT_READY);
    end
    @(posedge CLK);
    @(negedge CLK);
    BIT_VALID = 1'b0;
    n_cmp++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_delivered got v=%b exp=0", OUT_VALID);
    end
    send_code(9'b00010, 5, 0);
    n_cmp++;
    if (OUT !== 8'h63 || OUT_VALID !== 1'b1 || SYM_COUNT !== 4'd2) begin
      n_fail++;
      $display("FAIL bp_next got out=%h v=%b cnt=%0d exp 63/1/2", OUT, OUT_VALID, SYM_COUNT);
    end
  endtask

  task automatic test_eom();
    do_reset();
    send_code(9'b0_00000, 6, 0);
    send_code(9'b0_11011, 6, 0);
    send_code({1'b1, 8'h5A}, 9, 0);
    n_cmp++;
    if (SYM_COUNT !== 4'd3 || OUT !== 8'h5A) begin
      n_fail++;
      $display("FAIL eom_pre got cnt=%0d out=%h exp 3/5a", SYM_COUNT, OUT);
    end
    send_code(9'b0_11111, 6, 0);
    n_cmp++;
    if (EOM !== 1'b1 || SYM_COUNT !== 4'd0 || OUT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL eom_pulse got eom=%b cnt=%0d v=%b exp 1/0/0", EOM, SYM_COUNT, OUT_VALID);
    end
    @(negedge CLK);
    n_cmp++;
    if (EOM !== 1'b0 || OUT_VALID !== 1'b0 || OUT !== 8'h5A) begin
      n_fail++;
      $display("FAIL eom_after got eom=%b v=%b out=%h exp 0/0/5a", EOM, OUT_VALID, OUT);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) send_code(9'b0_00100, 6, 0);
    n_cmp++;
    if (SYM_COUNT !== 4'd15 || OUT !== 8'h65) begin
      n_fail++;
      $display("FAIL wrap_pre got cnt=%0d out=%h exp 15/65", SYM_COUNT, OUT);
    end
    send_code(9'b0_00100, 6, 0);
    n_cmp++;
    if (SYM_COUNT !== 4'd0 || OUT_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap got cnt=%0d v=%b exp 0/1", SYM_COUNT, OUT_VALID);
    end
  endtask

  task automatic test_mid_reset();
    send_code(9'b1010, 4, 0);
    RST_N = 1'b0;
    #2;
    n_cmp++;
    if (OUT !== 8'h00 || OUT_VALID !== 1'b0 || SYM_COUNT !== 4'd0 || STATE_DBG !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_clear got out=%h v=%b cnt=%0d st=%0d exp 00/0/0/0", OUT, OUT_VALID, SYM_COUNT, STATE_DBG);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    send_code(9'b0_00000, 6, 0);
    n_cmp++;
    if (OUT !== 8'h61 || OUT_VALID !== 1'b1 || SYM_COUNT !== 4'd1) begin
      n_fail++;
      $display("FAIL midrst_decode got out=%h v=%b cnt=%0d exp 61/1/1", OUT, OUT_VALID, SYM_COUNT);
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_literal();
    test_backpressure();
    test_eom();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
